// File: rtl/time_counter.sv
// BCD HH:MM current-time register: advances on timegen one_minute pulses and
// accepts validated keypad loads, pulsing time_loaded to restart timegen phase.
module time_counter #(
  parameter int HOURS_PER_DAY = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_minute,
  input  logic       load_new_c,
  input  logic [3:0] new_ms_hr,
  input  logic [3:0] new_ls_hr,
  input  logic [3:0] new_ms_min,
  input  logic [3:0] new_ls_min,
  output logic [3:0] current_ms_hr,
  output logic [3:0] current_ls_hr,
  output logic [3:0] current_ms_min,
  output logic [3:0] current_ls_min,
  output logic       time_loaded,
  output logic       load_err,
  output logic       day_wrap
);

  // Anything other than 12 falls back to a 24-hour day.
  localparam int         HPD       = (HOURS_PER_DAY == 12) ? 12 : 24;
  localparam logic [7:0] MAX_HOUR  = 8'(HPD - 1);
  localparam logic [3:0] MAX_MS_HR = 4'((HPD - 1) / 10);
  localparam logic [3:0] MAX_LS_HR = 4'((HPD - 1) % 10);

  logic [3:0] ms_hr_q, ls_hr_q, ms_min_q, ls_min_q;
  logic [3:0] ms_hr_d, ls_hr_d, ms_min_d, ls_min_d;
  logic       time_loaded_q, load_err_q, day_wrap_q;
  logic       time_loaded_d, load_err_d, day_wrap_d;

  logic [7:0] new_hour_val;
  logic       load_valid;
  logic       hour_at_max;

  always_comb begin
    new_hour_val = ({4'd0, new_ms_hr} * 8'd10) + {4'd0, new_ls_hr};
    load_valid   = (new_ms_hr  <= 4'd9) &&
                   (new_ls_hr  <= 4'd9) &&
                   (new_ms_min <= 4'd5) &&
                   (new_ls_min <= 4'd9) &&
                   (new_hour_val <= MAX_HOUR);
    hour_at_max  = (ms_hr_q == MAX_MS_HR) && (ls_hr_q == MAX_LS_HR);
  end

  // A load always wins the cycle; a coincident minute pulse is dropped.
  always_comb begin
    ms_hr_d       = ms_hr_q;
    ls_hr_d       = ls_hr_q;
    ms_min_d      = ms_min_q;
    ls_min_d      = ls_min_q;
    time_loaded_d = 1'b0;
    load_err_d    = 1'b0;
    day_wrap_d    = 1'b0;

    if (load_new_c) begin
      if (load_valid) begin
        ms_hr_d       = new_ms_hr;
        ls_hr_d       = new_ls_hr;
        ms_min_d      = new_ms_min;
        ls_min_d      = new_ls_min;
        time_loaded_d = 1'b1;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (one_minute) begin
      if (ls_min_q != 4'd9) begin
        ls_min_d = ls_min_q + 4'd1;
      end else begin
        ls_min_d = 4'd0;
        if (ms_min_q != 4'd5) begin
          ms_min_d = ms_min_q + 4'd1;
        end else begin
          ms_min_d = 4'd0;
          if (hour_at_max) begin
            ms_hr_d    = 4'd0;
            ls_hr_d    = 4'd0;
            day_wrap_d = 1'b1;
          end else if (ls_hr_q == 4'd9) begin
            ls_hr_d = 4'd0;
            ms_hr_d = ms_hr_q + 4'd1;
          end else begin
            ls_hr_d = ls_hr_q + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ms_hr_q       <= 4'd0;
      ls_hr_q       <= 4'd0;
      ms_min_q      <= 4'd0;
      ls_min_q      <= 4'd0;
      time_loaded_q <= 1'b0;
      load_err_q    <= 1'b0;
      day_wrap_q    <= 1'b0;
    end else begin
      ms_hr_q       <= ms_hr_d;
      ls_hr_q       <= ls_hr_d;
      ms_min_q      <= ms_min_d;
      ls_min_q      <= ls_min_d;
      time_loaded_q <= time_loaded_d;
      load_err_q    <= load_err_d;
      day_wrap_q    <= day_wrap_d;
    end
  end

  assign current_ms_hr  = ms_hr_q;
  assign current_ls_hr  = ls_hr_q;
  assign current_ms_min = ms_min_q;
  assign current_ls_min = ls_min_q;
  assign time_loaded    = time_loaded_q;
  assign load_err       = load_err_q;
  assign day_wrap       = day_wrap_q;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter: a 24-hour and a 12-hour instance share stimulus.
module tb_time_counter;

  logic       clock = 1'b0;
  logic       reset;
  logic       one_minute;
  logic       load_new_c;
  logic [3:0] new_ms_hr, new_ls_hr, new_ms_min, new_ls_min;

  logic [3:0] a_ms_hr, a_ls_hr, a_ms_min, a_ls_min;
  logic       a_tl, a_le, a_dw;
  logic [3:0] b_ms_hr, b_ls_hr, b_ms_min, b_ls_min;
  logic       b_tl, b_le, b_dw;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  time_counter #(.HOURS_PER_DAY(24)) u24 (
    .clock(clock), .reset(reset), .one_minute(one_minute), .load_new_c(load_new_c),
    .new_ms_hr(new_ms_hr), .new_ls_hr(new_ls_hr), .new_ms_min(new_ms_min), .new_ls_min(new_ls_min),
    .current_ms_hr(a_ms_hr), .current_ls_hr(a_ls_hr), .current_ms_min(a_ms_min), .current_ls_min(a_ls_min),
    .time_loaded(a_tl), .load_err(a_le), .day_wrap(a_dw)
  );

  time_counter #(.HOURS_PER_DAY(12)) u12 (
    .clock(clock), .reset(reset), .one_minute(one_minute), .load_new_c(load_new_c),
    .new_ms_hr(new_ms_hr), .new_ls_hr(new_ls_hr), .new_ms_min(new_ms_min), .new_ls_min(new_ls_min),
    .current_ms_hr(b_ms_hr), .current_ls_hr(b_ls_hr), .current_ms_min(b_ms_min), .current_ls_min(b_ls_min),
    .time_loaded(b_tl), .load_err(b_le), .day_wrap(b_dw)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_load(input logic [15:0] t);
    load_new_c = 1'b1;
    {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min} = t;
  endtask

  // Compares digits (as 16-bit HHMM) and pulses {time_loaded, load_err, day_wrap}.
  task automatic chk24(input string tag, input logic [15:0] exp_t, input logic [2:0] exp_p);
    logic [15:0] obs_t;
    logic [2:0]  obs_p;
    obs_t = {a_ms_hr, a_ls_hr, a_ms_min, a_ls_min};
    obs_p = {a_tl, a_le, a_dw};
    checks++;
    assert (obs_t === exp_t && obs_p === exp_p) else begin
      errors++;
      $error("FAIL %s (24h): time=%h pulses=%b, expected time=%h pulses=%b", tag, obs_t, obs_p, exp_t, exp_p);
    end
  endtask

  task automatic chk12(input string tag, input logic [15:0] exp_t, input logic [2:0] exp_p);
    logic [15:0] obs_t;
    logic [2:0]  obs_p;
    obs_t = {b_ms_hr, b_ls_hr, b_ms_min, b_ls_min};
    obs_p = {b_tl, b_le, b_dw};
    checks++;
    assert (obs_t === exp_t && obs_p === exp_p) else begin
      errors++;
      $error("FAIL %s (12h): time=%h pulses=%b, expected time=%h pulses=%b", tag, obs_t, obs_p, exp_t, exp_p);
    end
  endtask

  initial begin
    reset      = 1'b0;
    one_minute = 1'b0;
    load_new_c = 1'b0;
    {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min} = 16'h0000;

    tick(); tick();
    chk24("reset_held", 16'h0000, 3'b000);
    chk12("reset_held", 16'h0000, 3'b000);
    reset = 1'b1;
    tick(); tick();
    chk24("idle_after_release", 16'h0000, 3'b000);

    // Single-cycle valid load
    set_load(16'h1234); tick(); load_new_c = 1'b0;
    chk24("load_1234", 16'h1234, 3'b100);
    tick();
    chk24("load_1234_pulse_end", 16'h1234, 3'b000);

    // 23:59 rolls over the day on the 24h instance
    set_load(16'h2359); tick(); load_new_c = 1'b0;
    chk24("load_2359", 16'h2359, 3'b100);
    one_minute = 1'b1; tick(); one_minute = 1'b0;
    chk24("wrap_2359", 16'h0000, 3'b001);
    tick();
    chk24("wrap_pulse_end", 16'h0000, 3'b000);

    // 11:59: day wrap on 12h, plain hour carry on 24h
    set_load(16'h1159); tick(); load_new_c = 1'b0;
    chk12("load_1159", 16'h1159, 3'b100);
    one_minute = 1'b1; tick(); one_minute = 1'b0;
    chk12("wrap_1159", 16'h0000, 3'b001);
    chk24("carry_1159", 16'h1200, 3'b000);

    // Decimal carries
    set_load(16'h0959); tick(); load_new_c = 1'b0;
    one_minute = 1'b1; tick(); one_minute = 1'b0;
    chk24("carry_0959", 16'h1000, 3'b000);
    set_load(16'h1959); tick(); load_new_c = 1'b0;
    one_minute = 1'b1; tick(); one_minute = 1'b0;
    chk24("carry_1959", 16'h2000, 3'b000);
    set_load(16'h0009); tick(); load_new_c = 1'b0;
    one_minute = 1'b1; tick(); one_minute = 1'b0;
    chk24("carry_0009", 16'h0010, 3'b000);

    // Back-to-back minute pulses each count
    one_minute = 1'b1; tick(); tick(); tick(); one_minute = 1'b0;
    chk24("three_minutes", 16'h0013, 3'b000);

    // Invalid loads leave 05:05 untouched
    set_load(16'h0505); tick(); load_new_c = 1'b0;
    chk24("load_0505", 16'h0505, 3'b100);
    set_load(16'h2400); tick(); load_new_c = 1'b0;
    chk24("bad_2400", 16'h0505, 3'b010);
    tick();
    chk24("bad_2400_pulse_end", 16'h0505, 3'b000);
    set_load(16'h1260); tick(); load_new_c = 1'b0;
    chk24("bad_1260", 16'h0505, 3'b010);
    chk12("bad_1260", 16'h0505, 3'b010);
    tick();
    set_load(16'h1A00); tick(); load_new_c = 1'b0;
    chk24("bad_1A00", 16'h0505, 3'b010);
    tick();
    set_load(16'h1200); tick(); load_new_c = 1'b0;
    chk12("bad_1200_12h", 16'h0505, 3'b010);
    chk24("ok_1200_24h", 16'h1200, 3'b100);

    // Load held for two cycles keeps time_loaded high for two cycles
    set_load(16'h0630); tick();
    chk24("hold_load_c1", 16'h0630, 3'b100);
    set_load(16'h0631); tick(); load_new_c = 1'b0;
    chk24("hold_load_c2", 16'h0631, 3'b100);
    tick();
    chk24("hold_load_end", 16'h0631, 3'b000);

    // Load beats a coincident minute pulse
    set_load(16'h0715); one_minute = 1'b1; tick();
    load_new_c = 1'b0; one_minute = 1'b0;
    chk24("load_vs_minute", 16'h0715, 3'b100);
    tick();

    // Asynchronous reset mid-count clears before the next edge
    one_minute = 1'b1;
    #2 reset = 1'b0;
    #1 chk24("async_reset", 16'h0000, 3'b000);
    one_minute = 1'b0;

    // Reset held through a load cycle, then released with no pulse
    tick();
    set_load(16'h0808); tick();
    chk24("reset_during_load", 16'h0000, 3'b000);
    load_new_c = 1'b0;
    reset = 1'b1;
    tick();
    chk24("release_no_pulse", 16'h0000, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
